s3g_rx_multi: RTL
=================

Name: s3g_rx_multi

Overview:
Parametrised S3G packet receiver that frames packets from NCH byte-stream UART channels: 0xD5 start byte, length byte, payload, then CRC-8. Round-robin arbitration picks which channel owns the receiver. It adds a length limit, an inter-byte timeout and error classification. The payload goes into an internal RAM with a registered read port, and the first HEAD_BYTES bytes are also exposed as a flat vector for the command decoder.

Parameters:
NCH, 2, number of input byte channels (1..8)
MAX_LEN, 64, maximum accepted payload length in bytes (1..255); sets RAM depth
HEAD_BYTES, 16, payload bytes mirrored onto head_bytes (1..MAX_LEN)
TIMEOUT, 100000, max clocks between accepted bytes inside a packet; 0 disables the timeout
SRC_W, 3, width of src_chan (>= clog2(NCH), min 1)

Ports:
clk  input  1  system clock
rst  input  1  reset: synchronous, active-low
rx_data  input  NCH*8  per-channel received byte; channel k occupies bits [8k+7:8k]
rx_done  input  NCH  per-channel one-cycle byte-valid strobe
packet_done  output  1  one-cycle pulse: good packet received
packet_error  output  1  one-cycle pulse: packet aborted
error_code  output  2  cause of last error: 0 none, 1 CRC mismatch, 2 length > MAX_LEN, 3 timeout; held until the next error or reset
src_chan  output  SRC_W  channel that owns the current or last packet
payload_len  output  8  length byte of the current or last packet
buffer_valid  output  1  high while the RAM and head hold a complete good packet
buffer_addr  input  8  RAM read address
buffer_data  output  8  RAM read data, 1-cycle registered latency
head_bytes  output  HEAD_BYTES*8  payload byte i at bits [8i+7:8i]; bytes not received read 0

Behaviour:
- Reset (rst==0 at a clock edge): state goes to S_INIT and all outputs go to 0. This includes head_bytes, error_code and the round-robin pointer. RAM contents are don't-care. Reset mid-packet abandons the packet with no pulse.
- States and transitions:
  - S_INIT: candidate channels are those with rx_done[k] && rx_data[k]==0xD5. Grant the first candidate at or after rr_ptr (wrapping). Latch it into src_chan, set rr_ptr=(k+1) mod NCH, go to S_LEN. Non-D5 bytes are ignored.
  - S_LEN: accept a byte on the owner channel. Set payload_len=byte, clear buffer_valid, clear head_bytes, crc=0, wr_addr=0, cnt=byte.
    - byte > MAX_LEN: error code 2, return to S_INIT.
    - byte==0: go to S_CRC.
    - otherwise: go to S_DATA.
  - S_DATA: each owner byte is written to RAM[wr_addr]. If wr_addr < HEAD_BYTES it is also written to head byte wr_addr. Update crc, increment wr_addr, decrement cnt. When cnt==1, go to S_CRC.
  - S_CRC: the owner byte is compared with crc.
    - Equal: packet_done pulse, buffer_valid=1.
    - Not equal: error code 1.
    - Either way, go to S_INIT.
- Bytes from non-owner channels are ignored outside S_INIT. They are dropped, not queued.
- CRC is Maxim/Dallas CRC-8: reflected polynomial 0x8C, LSB-first, init 0x00, no final XOR. It covers payload bytes only.
- Timeout counter:
  - Cleared on S_INIT→S_LEN and on every accepted owner byte.
  - Increments in S_LEN, S_DATA and S_CRC.
  - On reaching TIMEOUT: error code 3, return to S_INIT.
  - An accepted byte in the same cycle as the timeout wins.
- Error action: packet_error pulses one cycle after the offending byte or timeout, error_code updates in the same cycle, buffer_valid stays 0.
- packet_done/packet_error are registered: they assert the clock after the CRC byte strobe. S_INIT accepts a new 0xD5 from the cycle after the CRC byte.
- The RAM read port operates regardless of state. Reading while a new packet is arriving returns the mixed old/new contents; buffer_valid==0 flags this.
- At most one byte is accepted per clock.

Test Plan:
- Ch0: D5, 01, 01, 5E -> packet_done pulse 1 clk after the 0x5E strobe; buffer_valid=1, payload_len=1, src_chan=0, head byte0=0x01, buffer_data@addr0=0x01 one clk after the address is applied.
- Ch1: D5, 01, 01, 5F -> packet_error pulse, error_code=1, buffer_valid=0, src_chan=1.
- Ch0 and ch1 both strobe D5 in the same cycle after reset -> ch0 granted; ch1's subsequent bytes ignored. Repeat the simultaneous D5 after completion -> ch1 granted.
- MAX_LEN=64, length byte 0x41 -> error_code=2, state S_INIT. Then D5, 00, 00 -> packet_done, payload_len=0, head_bytes all 0.
- TIMEOUT=10: D5, 03, AA, then silence -> packet_error exactly 10 clks after the AA strobe, error_code=3. A byte arriving on the 10th clock instead continues the packet.
- rst low during S_DATA of a 20-byte packet -> all outputs 0 next clk. A new complete packet afterwards is received correctly.

Source files
------------

// File: rtl/s3g_rx_multi.sv
// rtl/s3g_rx_multi.sv - round-robin multi-channel S3G packet receiver
// Frames D5/len/payload/CRC-8 packets into a payload RAM plus a flat head-byte mirror.
module s3g_rx_multi #(
  parameter int NCH        = 2,
  parameter int MAX_LEN    = 64,
  parameter int HEAD_BYTES = 16,
  parameter int TIMEOUT    = 100000,
  parameter int SRC_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH*8-1:0]        rx_data,
  input  logic [NCH-1:0]          rx_done,
  output logic                    packet_done,
  output logic                    packet_error,
  output logic [1:0]              error_code,
  output logic [SRC_W-1:0]        src_chan,
  output logic [7:0]              payload_len,
  output logic                    buffer_valid,
  input  logic [7:0]              buffer_addr,
  output logic [7:0]              buffer_data,
  output logic [HEAD_BYTES*8-1:0] head_bytes
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
  localparam logic [8:0] MAX_LEN_9 = 9'(MAX_LEN);

  typedef enum logic [1:0] {S_INIT, S_LEN, S_DATA, S_CRC} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [SRC_W-1:0]        r_rr_ptr;
  logic [SRC_W-1:0]        r_src_chan;
  logic [7:0]              r_payload_len;
  logic                    r_buffer_valid;
  logic [HEAD_BYTES*8-1:0] r_head;
  logic [7:0]              r_crc;
  logic [7:0]              r_wr_addr;
  logic [7:0]              r_cnt;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    r_packet_done;
  logic                    r_packet_error;
  logic [1:0]              r_error_code;
  logic [7:0]              r_buffer_data;
  logic [7:0]              r_ram [MAX_LEN];

  logic                    w_grant;
  logic [SRC_W-1:0]        w_grant_ch;
  logic [SRC_W-1:0]        w_grant_nxt;
  int                      w_best;
  logic                    w_own_done;
  logic [7:0]              w_own_data;
  logic                    w_timeout;
  logic                    w_len_big;
  logic                    w_rd_ok;
  logic                    w_ram_we;
  logic [7:0]              w_crc_next;

  // Maxim/Dallas CRC-8: reflected poly 0x8C, LSB first
  function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // Pick the D5 candidate with the smallest rotational distance from r_rr_ptr
  always_comb begin
    w_grant     = 1'b0;
    w_grant_ch  = '0;
    w_grant_nxt = '0;
    w_best      = NCH;
    for (int k = 0; k < NCH; k++) begin
      if (rx_done[k] && (rx_data[8*k +: 8] == 8'hD5) &&
          (((k - int'(r_rr_ptr) + NCH) % NCH) < w_best)) begin
        w_best      = (k - int'(r_rr_ptr) + NCH) % NCH;
        w_grant     = 1'b1;
        w_grant_ch  = SRC_W'(k);
        w_grant_nxt = SRC_W'((k + 1) % NCH);
      end
    end
  end

  always_comb begin
    w_own_done = 1'b0;
    w_own_data = 8'h00;
    for (int k = 0; k < NCH; k++) begin
      if (r_src_chan == SRC_W'(k)) begin
        w_own_done = rx_done[k];
        w_own_data = rx_data[8*k +: 8];
      end
    end
  end

  assign w_timeout  = (TIMEOUT != 0) && (r_state != S_INIT) && !w_own_done && (r_to_cnt == TO_LAST);
  assign w_len_big  = {1'b0, w_own_data} > MAX_LEN_9;
  assign w_rd_ok    = {1'b0, buffer_addr} < MAX_LEN_9;
  assign w_ram_we   = (r_state == S_DATA) && w_own_done;
  assign w_crc_next = f_crc8(r_crc, w_own_data);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_INIT;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT: if (w_grant) w_state_next = S_LEN;
      S_LEN: begin
        if (w_own_done) begin
          if (w_len_big)                w_state_next = S_INIT;
          else if (w_own_data == 8'h00) w_state_next = S_CRC;
          else                          w_state_next = S_DATA;
        end else if (w_timeout) begin
          w_state_next = S_INIT;
        end
      end
      S_DATA: begin
        if (w_own_done) begin
          if (r_cnt == 8'd1) w_state_next = S_CRC;
        end else if (w_timeout) begin
          w_state_next = S_INIT;
        end
      end
      S_CRC: if (w_own_done || w_timeout) w_state_next = S_INIT;
      default: w_state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr       <= '0;
      r_src_chan     <= '0;
      r_payload_len  <= 8'h00;
      r_buffer_valid <= 1'b0;
      r_head         <= '0;
      r_crc          <= 8'h00;
      r_wr_addr      <= 8'h00;
      r_cnt          <= 8'h00;
      r_to_cnt       <= '0;
      r_packet_done  <= 1'b0;
      r_packet_error <= 1'b0;
      r_error_code   <= 2'd0;
      r_buffer_data  <= 8'h00;
    end else begin
      r_packet_done  <= 1'b0;
      r_packet_error <= 1'b0;
      r_buffer_data  <= w_rd_ok ? r_ram[buffer_addr[AW-1:0]] : 8'h00;
      if (r_state == S_INIT) begin
        r_to_cnt <= '0;
        if (w_grant) begin
          r_src_chan <= w_grant_ch;
          r_rr_ptr   <= w_grant_nxt;
        end
      end else if (w_own_done) begin
        // An accepted byte always beats a timeout landing on the same edge
        r_to_cnt <= '0;
        case (r_state)
          S_LEN: begin
            r_payload_len  <= w_own_data;
            r_buffer_valid <= 1'b0;
            r_head         <= '0;
            r_crc          <= 8'h00;
            r_wr_addr      <= 8'h00;
            r_cnt          <= w_own_data;
            if (w_len_big) begin
              r_packet_error <= 1'b1;
              r_error_code   <= 2'd2;
            end
          end
          S_DATA: begin
            r_crc     <= w_crc_next;
            r_wr_addr <= r_wr_addr + 8'd1;
            r_cnt     <= r_cnt - 8'd1;
            for (int i = 0; i < HEAD_BYTES; i++) begin
              if (r_wr_addr == 8'(i)) r_head[8*i +: 8] <= w_own_data;
            end
          end
          S_CRC: begin
            if (w_own_data == r_crc) begin
              r_packet_done  <= 1'b1;
              r_buffer_valid <= 1'b1;
            end else begin
              r_packet_error <= 1'b1;
              r_error_code   <= 2'd1;
            end
          end
          default: ;
        endcase
      end else if (w_timeout) begin
        r_packet_error <= 1'b1;
        r_error_code   <= 2'd3;
        r_buffer_valid <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // Payload RAM has no reset; contents are meaningful only while buffer_valid
  always_ff @(posedge clk) begin
    if (rst && w_ram_we) r_ram[r_wr_addr[AW-1:0]] <= w_own_data;
  end

  assign packet_done  = r_packet_done;
  assign packet_error = r_packet_error;
  assign error_code   = r_error_code;
  assign src_chan     = r_src_chan;
  assign payload_len  = r_payload_len;
  assign buffer_valid = r_buffer_valid;
  assign buffer_data  = r_buffer_data;
  assign head_bytes   = r_head;

endmodule
